// File: rtl/rv32i_mmio_pkg.sv
// Shared definitions for the RV32I memory-mapped timer: register map,
// control/status bit positions and reset constants.
package rv32i_mmio_pkg;

  // Byte offsets of the timer registers inside the 32-byte block
  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_PRESCALE = 5'h04;
  localparam logic [4:0] OFF_COUNT    = 5'h08;
  localparam logic [4:0] OFF_COMPARE  = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;

  // Word index (address bits [4:2]) of each register
  typedef enum logic [2:0] {
    REG_CTRL     = OFF_CTRL[4:2],
    REG_PRESCALE = OFF_PRESCALE[4:2],
    REG_COUNT    = OFF_COUNT[4:2],
    REG_COMPARE  = OFF_COMPARE[4:2],
    REG_STATUS   = OFF_STATUS[4:2]
  } reg_idx_e;

  // CTRL bit positions
  localparam int CTRL_W           = 3;
  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  // STATUS bit positions (both flags are sticky, write-1-to-clear)
  localparam int STATUS_W     = 2;
  localparam int STATUS_MATCH = 0;
  localparam int STATUS_OVF   = 1;

  // Reset constants
  localparam int          PRESCALE_W  = 16;
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the MMIO timer: issues one tick every prescale+1 cycles
// while enabled, and holds its phase at zero while disabled.
module timer_prescaler
  import rv32i_mmio_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = en && (pcnt == prescale);

  // Phase counter: cleared when disabled or on a tick, otherwise counts up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (!en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/rv32i_mmio_timer.sv
// Memory-mapped timer on the RV32I data bus: register file, address
// decode, prescaled counter with compare/auto-reload, sticky flags and irq.
// Reads are combinational so a load completes in the same cycle.
module rv32i_mmio_timer
  import rv32i_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Memwrite,
  input  logic [31:0] Memaddr,
  input  logic [31:0] MemWdata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [CTRL_W-1:0]     ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic [STATUS_W-1:0]   status;

  logic [31:0]           count_next;
  logic [STATUS_W-1:0]   status_set;
  logic [STATUS_W-1:0]   status_clr;
  logic [STATUS_W-1:0]   status_next;

  reg_idx_e              idx;
  logic                  wr_any;
  logic                  wr_ctrl;
  logic                  wr_prescale;
  logic                  wr_count;
  logic                  wr_compare;
  logic                  wr_status;
  logic                  tick;
  logic                  unused_addr_bits;

  assign sel         = (Memaddr[31:5] == BASE_ADDR[31:5]);
  assign idx         = reg_idx_e'(Memaddr[4:2]);
  assign wr_any      = Memwrite & sel;
  assign wr_ctrl     = wr_any & (idx == REG_CTRL);
  assign wr_prescale = wr_any & (idx == REG_PRESCALE);
  assign wr_count    = wr_any & (idx == REG_COUNT);
  assign wr_compare  = wr_any & (idx == REG_COMPARE);
  assign wr_status   = wr_any & (idx == REG_STATUS);

  // Byte-lane bits carry no meaning for word-only accesses
  assign unused_addr_bits = ^Memaddr[1:0];

  assign irq = ctrl[CTRL_IRQ_EN] & status[STATUS_MATCH];

  // The prescaler sees the registered EN, so a CTRL write only affects later edges
  timer_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl[CTRL_EN]),
    .prescale (prescale),
    .tick     (tick)
  );

  // Counter next value and flag set events; a CPU write to COUNT overrides the tick
  always_comb begin
    count_next = count;
    status_set = '0;
    if (wr_count) begin
      count_next = MemWdata;
    end else if (tick) begin
      if (count == compare) begin
        status_set[STATUS_MATCH] = 1'b1;
        count_next = ctrl[CTRL_AUTO_RELOAD] ? 32'd0 : count + 32'd1;
      end else begin
        count_next = count + 32'd1;
        status_set[STATUS_OVF] = (count == 32'hFFFF_FFFF);
      end
    end
  end

  // Sticky flags: write-1-to-clear, but a set in the same cycle wins
  always_comb begin
    status_clr  = wr_status ? MemWdata[STATUS_W-1:0] : '0;
    status_next = (status & ~status_clr) | status_set;
  end

  // Configuration registers written directly from the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= COMPARE_RST;
    end else begin
      if (wr_ctrl) begin
        ctrl <= MemWdata[CTRL_W-1:0];
      end
      if (wr_prescale) begin
        prescale <= MemWdata[PRESCALE_W-1:0];
      end
      if (wr_compare) begin
        compare <= MemWdata;
      end
    end
  end

  // Counter and status state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      status <= '0;
    end else begin
      count  <= count_next;
      status <= status_next;
    end
  end

  // Combinational read mux; unmapped words and unselected addresses read zero
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (idx)
        REG_CTRL:     rdata = {{(32-CTRL_W){1'b0}}, ctrl};
        REG_PRESCALE: rdata = {{(32-PRESCALE_W){1'b0}}, prescale};
        REG_COUNT:    rdata = count;
        REG_COMPARE:  rdata = compare;
        REG_STATUS:   rdata = {{(32-STATUS_W){1'b0}}, status};
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mmio_timer.sv
// Self-checking bench for rv32i_mmio_timer: directed scenarios plus a
// randomized bus sequence, all checked against a cycle-level behavioural model.
module tb_rv32i_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Memwrite = 1'b0;
  logic [31:0] Memaddr = BASE;
  logic [31:0] MemWdata = 32'd0;
  logic        sel;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [2:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [15:0] m_phase;
  logic [31:0] m_count;
  logic [31:0] m_cmp;
  logic [1:0]  m_status;

  // Model scratch
  bit          t_tick;
  bit          t_wr;
  logic [4:0]  t_off;
  logic [1:0]  t_set;
  logic [32:0] t_inc;

  rv32i_mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .Memwrite (Memwrite),
    .Memaddr  (Memaddr),
    .MemWdata (MemWdata),
    .sel      (sel),
    .rdata    (rdata),
    .irq      (irq)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  function automatic bit in_block(logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    case ({a[4:2], 2'b00})
      5'h00:   return {29'd0, m_ctrl};
      5'h04:   return {16'd0, m_pre};
      5'h08:   return m_count;
      5'h0C:   return m_cmp;
      5'h10:   return {30'd0, m_status};
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: one step per rising edge, from the bus inputs seen at that edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl = 3'd0; m_pre = 16'd0; m_phase = 16'd0;
      m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_status = 2'd0;
    end else begin
      t_tick = m_ctrl[0] && (m_phase == m_pre);
      t_wr   = Memwrite && in_block(Memaddr);
      t_off  = {Memaddr[4:2], 2'b00};
      t_set  = 2'b00;
      m_phase = (!m_ctrl[0] || t_tick) ? 16'd0 : m_phase + 16'd1;
      if (t_wr && t_off == 5'h08) begin
        m_count = MemWdata;
      end else if (t_tick) begin
        if (m_count == m_cmp) begin
          t_set[0] = 1'b1;
          m_count = m_ctrl[1] ? 32'd0 : m_count + 32'd1;
        end else begin
          t_inc = {1'b0, m_count} + 33'd1;
          m_count = t_inc[31:0];
          t_set[1] = t_inc[32];
        end
      end
      if (t_wr && t_off == 5'h10) m_status = m_status & ~MemWdata[1:0];
      m_status = m_status | t_set;
      if (t_wr && t_off == 5'h00) m_ctrl = MemWdata[2:0];
      if (t_wr && t_off == 5'h04) m_pre = MemWdata[15:0];
      if (t_wr && t_off == 5'h0C) m_cmp = MemWdata;
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Memaddr = a; MemWdata = d; Memwrite = 1'b1;
    @(posedge clk); #1;
    Memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    Memwrite = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] v, output logic s);
    Memwrite = 1'b0; Memaddr = a;
    #1;
    v = rdata; s = sel;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic s;
    logic [31:0] rst_vals [8];
    rst_vals = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_reg(BASE + 32'(4 * i), v, s);
      checks++;
      if (v !== rst_vals[i]) begin
        failures++; $display("FAIL reset_read off=%0h: got %h expected %h", 4 * i, v, rst_vals[i]);
      end
      checks++;
      if (s !== 1'b1) begin failures++; $display("FAIL reset_sel off=%0h: got %b expected 1", 4 * i, s); end
    end
    read_reg(BASE + 32'h20, v, s);
    checks++;
    if (s !== 1'b0) begin failures++; $display("FAIL sel_outside: got %b expected 0", s); end
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    logic s;
    logic [31:0] frozen;
    bus_write(BASE + 32'h04, 32'd3);
    bus_write(BASE + 32'h08, 32'd0);
    bus_write(BASE + 32'h00, 32'd1);
    for (int k = 1; k <= 24; k++) begin
      idle(1);
      read_reg(BASE + 32'h08, v, s);
      checks++;
      if (v !== m_count) begin failures++; $display("FAIL prescale_count k=%0d: got %h expected %h", k, v, m_count); end
      if (k == 3 || k == 4 || k == 20) begin
        checks++;
        if (v !== ((k == 3) ? 32'd0 : (k == 4) ? 32'd1 : 32'd5)) begin
          failures++; $display("FAIL prescale_fixed k=%0d: got %h", k, v);
        end
      end
    end
    bus_write(BASE + 32'h00, 32'd0);
    frozen = m_count;
    idle(10);
    read_reg(BASE + 32'h08, v, s);
    checks++;
    if (v !== 32'd6 || v !== frozen) begin
      failures++; $display("FAIL prescale_freeze: got %h expected %h", v, 32'd6);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic [31:0] st;
    logic s;
    bus_write(BASE + 32'h00, 32'd0);
    bus_write(BASE + 32'h04, 32'd0);
    bus_write(BASE + 32'h0C, 32'd9);
    bus_write(BASE + 32'h10, 32'd3);
    bus_write(BASE + 32'h08, 32'd0);
    bus_write(BASE + 32'h00, 32'd7);
    for (int k = 1; k <= 14; k++) begin
      idle(1);
      read_reg(BASE + 32'h08, v, s);
      read_reg(BASE + 32'h10, st, s);
      checks++;
      if (v !== m_count || st !== {30'd0, m_status} || irq !== (m_ctrl[2] & m_status[0])) begin
        failures++; $display("FAIL reload_model k=%0d: got count=%h status=%h irq=%b expected count=%h status=%h",
                             k, v, st, irq, m_count, m_status);
      end
      if (k == 9) begin
        checks++;
        if (v !== 32'd9 || st !== 32'd0 || irq !== 1'b0) begin
          failures++; $display("FAIL reload_before_match: got count=%h status=%h irq=%b expected 9/0/0", v, st, irq);
        end
      end
      if (k == 10) begin
        checks++;
        if (v !== 32'd0 || st !== 32'd1 || irq !== 1'b1) begin
          failures++; $display("FAIL reload_match: got count=%h status=%h irq=%b expected 0/1/1", v, st, irq);
        end
      end
    end
    bus_write(BASE + 32'h10, 32'd1);
    read_reg(BASE + 32'h10, st, s);
    checks++;
    if (st !== 32'd0 || irq !== 1'b0) begin
      failures++; $display("FAIL reload_w1c: got status=%h irq=%b expected 0/0", st, irq);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [31:0] st;
    logic s;
    logic [31:0] exp_c [5];
    logic [31:0] exp_s [5];
    exp_c = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1};
    exp_s = '{32'd0, 32'd2, 32'd2, 32'd2, 32'd0};
    bus_write(BASE + 32'h00, 32'd0);
    bus_write(BASE + 32'h0C, 32'd5);
    bus_write(BASE + 32'h10, 32'd3);
    bus_write(BASE + 32'h04, 32'd0);
    bus_write(BASE + 32'h08, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h00, 32'd1);
    for (int k = 0; k < 5; k++) begin
      case (k)
        0, 1:    idle(1);
        2:       bus_write(BASE + 32'h08, 32'hFFFF_FFFF);
        default: bus_write(BASE + 32'h10, 32'd2);
      endcase
      read_reg(BASE + 32'h08, v, s);
      read_reg(BASE + 32'h10, st, s);
      checks++;
      if (v !== exp_c[k] || st !== exp_s[k] || v !== m_count || st !== {30'd0, m_status}) begin
        failures++; $display("FAIL overflow step=%0d: got count=%h status=%h expected count=%h status=%h",
                             k, v, st, exp_c[k], exp_s[k]);
      end
    end
  endtask

  task automatic test_write_tick_and_reset();
    logic [31:0] v;
    logic s;
    logic [31:0] rst_vals [5];
    rst_vals = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
    bus_write(BASE + 32'h00, 32'd0);
    bus_write(BASE + 32'h10, 32'd3);
    bus_write(BASE + 32'h04, 32'd0);
    bus_write(BASE + 32'h0C, 32'd3);
    bus_write(BASE + 32'h08, 32'd0);
    bus_write(BASE + 32'h00, 32'd7);
    idle(6);
    checks++;
    if (irq !== 1'b1 || irq !== (m_ctrl[2] & m_status[0])) begin
      failures++; $display("FAIL match_irq: got %b expected 1", irq);
    end
    bus_write(BASE + 32'h08, 32'd100);
    read_reg(BASE + 32'h08, v, s);
    checks++;
    if (v !== 32'd100) begin failures++; $display("FAIL count_write_tick: got %h expected %h", v, 32'd100); end
    idle(1);
    read_reg(BASE + 32'h08, v, s);
    checks++;
    if (v !== 32'd101) begin failures++; $display("FAIL count_after_write: got %h expected %h", v, 32'd101); end
    reset = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
    for (int i = 0; i < 5; i++) begin
      read_reg(BASE + 32'(4 * i), v, s);
      checks++;
      if (v !== rst_vals[i]) begin
        failures++; $display("FAIL async_reset off=%0h: got %h expected %h", 4 * i, v, rst_vals[i]);
      end
    end
    reset = 1'b0;
    bus_write(BASE + 32'h04, 32'd2);
    bus_write(BASE + 32'h00, 32'd1);
    idle(2);
    read_reg(BASE + 32'h08, v, s);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL reenable_early: got %h expected 0", v); end
    idle(1);
    read_reg(BASE + 32'h08, v, s);
    checks++;
    if (v !== 32'd1) begin failures++; $display("FAIL reenable_first_tick: got %h expected 1", v); end
  endtask

  task automatic test_outside();
    logic [31:0] v;
    logic s;
    logic [31:0] addr;
    logic [31:0] expv [5];
    expv = '{32'd0, 32'h55, 32'h1234_5678, 32'h777, 32'd0};
    bus_write(BASE + 32'h00, 32'd0);
    bus_write(BASE + 32'h04, 32'h55);
    bus_write(BASE + 32'h08, 32'h1234_5678);
    bus_write(BASE + 32'h0C, 32'h777);
    bus_write(BASE + 32'h10, 32'd3);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 3; j++) begin
        addr = BASE + 32'(4 * i);
        addr = (j == 0) ? addr + 32'h20 : (j == 1) ? addr - 32'h20 : addr ^ 32'h8000_0000;
        Memaddr = addr; MemWdata = 32'hFFFF_FFFF; Memwrite = 1'b1;
        #1;
        checks++;
        if (sel !== 1'b0) begin failures++; $display("FAIL outside_sel addr=%h: got %b expected 0", addr, sel); end
        @(posedge clk); #1;
        Memwrite = 1'b0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      read_reg(BASE + 32'(4 * i), v, s);
      checks++;
      if (v !== expv[i] || v !== model_read(BASE + 32'(4 * i))) begin
        failures++; $display("FAIL outside_unchanged off=%0h: got %h expected %h", 4 * i, v, expv[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic s;
    logic [31:0] a;
    logic [31:0] d;
    int off;
    bus_write(BASE + 32'h00, 32'd0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        off = 4 * $urandom_range(0, 5);
        case (off)
          0:  d = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
          4:  d = 32'($urandom_range(0, 3));
          8:  d = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 12)) : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          12: d = 32'($urandom_range(0, 12));
          16: d = 32'($urandom_range(0, 3));
          default: d = $urandom;
        endcase
        a = BASE + 32'(off) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a ^ 32'h0000_0100;
        Memaddr = a; MemWdata = d; Memwrite = 1'b1;
        #1;
        checks++;
        if (sel !== in_block(a)) begin failures++; $display("FAIL rand_sel addr=%h: got %b expected %b", a, sel, in_block(a)); end
        @(posedge clk); #1;
        Memwrite = 1'b0;
      end else begin
        idle(1);
      end
      for (int i = 0; i < 5; i++) begin
        read_reg(BASE + 32'(4 * i), v, s);
        checks++;
        if (v !== model_read(BASE + 32'(4 * i))) begin
          failures++; $display("FAIL rand_read n=%0d off=%0h: got %h expected %h", n, 4 * i, v, model_read(BASE + 32'(4 * i)));
        end
      end
      checks++;
      if (irq !== (m_ctrl[2] & m_status[0])) begin
        failures++; $display("FAIL rand_irq n=%0d: got %b expected %b", n, irq, m_ctrl[2] & m_status[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_autoreload();
    test_overflow();
    test_write_tick_and_reset();
    test_outside();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
